// File: rtl/damage_controller.sv
// Damage bookkeeping for one player and three enemies, driven once per collision pass.
// Optional build macro: DAMAGE_REGEN_EN (slow player HP regeneration on frame_tick).
module damage_controller #(
    parameter int PLAYER_HP     = 6,
    parameter int ENEMY_HP      = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int STUN_FRAMES   = 20,
    parameter int REGEN_FRAMES  = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       frame_tick,
    input  logic       collision_done,
    input  logic [2:0] c_e_collision,
    input  logic [2:0] e_hit,
    output logic [2:0] player_hp,
    output logic       player_invuln,
    output logic [2:0] enemy_alive,
    output logic [2:0] enemy_stun,
    output logic       game_over,
    output logic       all_cleared,
    output logic       update_done
);

    localparam logic [2:0] PLAYER_HP_INIT = 3'(PLAYER_HP);
    localparam logic [2:0] ENEMY_HP_INIT  = 3'(ENEMY_HP);
    localparam logic [7:0] INVULN_LOAD    = 8'(INVULN_FRAMES);
    localparam logic [7:0] STUN_LOAD      = 8'(STUN_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ENEMY0,
        S_ENEMY1,
        S_ENEMY2,
        S_PLAYER,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic       done_prev_reg;
    logic       done_edge;
    logic [2:0] col_latch_reg;
    logic [2:0] hit_latch_reg;
    logic [2:0] enemy_sel;
    logic       player_step;
    logic       player_dmg;
    logic       regen_fire;

    logic [2:0] hp_reg;
    logic [7:0] invuln_reg;
    logic       game_over_reg;

    assign done_edge = collision_done & ~done_prev_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            done_prev_reg <= 1'b0;
        end else if (init) begin
            state_reg     <= S_IDLE;
            done_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            done_prev_reg <= collision_done;
        end
    end

    always_comb begin
        state_next  = state_reg;
        enemy_sel   = 3'b000;
        player_step = 1'b0;
        update_done = 1'b0;
        case (state_reg)
            S_IDLE:   if (done_edge && !game_over_reg) state_next = S_LATCH;
            S_LATCH:  state_next = S_ENEMY0;
            S_ENEMY0: begin enemy_sel = 3'b001; state_next = S_ENEMY1; end
            S_ENEMY1: begin enemy_sel = 3'b010; state_next = S_ENEMY2; end
            S_ENEMY2: begin enemy_sel = 3'b100; state_next = S_PLAYER; end
            S_PLAYER: begin player_step = 1'b1; state_next = S_DONE; end
            S_DONE:   begin update_done = 1'b1; state_next = S_IDLE; end
            default:  state_next = S_IDLE;
        endcase
    end

    // Inputs are frozen for the whole pass so late changes cannot leak in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_latch_reg <= 3'b000;
            hit_latch_reg <= 3'b000;
        end else if (init) begin
            col_latch_reg <= 3'b000;
            hit_latch_reg <= 3'b000;
        end else if (state_reg == S_LATCH) begin
            col_latch_reg <= c_e_collision;
            hit_latch_reg <= e_hit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_enemy
            logic [2:0] ehp_reg;
            logic [7:0] stun_reg;
            logic       alive_reg;
            logic       hit_now;

            assign hit_now = enemy_sel[gi] & hit_latch_reg[gi] & alive_reg & (stun_reg == 8'd0);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    ehp_reg   <= ENEMY_HP_INIT;
                    stun_reg  <= 8'd0;
                    alive_reg <= 1'b1;
                end else if (init) begin
                    ehp_reg   <= ENEMY_HP_INIT;
                    stun_reg  <= 8'd0;
                    alive_reg <= 1'b1;
                end else if (hit_now) begin
                    // The killing blow also drops the stun so a dead enemy reports no stun.
                    if (ehp_reg <= 3'd1) begin
                        ehp_reg   <= 3'd0;
                        alive_reg <= 1'b0;
                        stun_reg  <= 8'd0;
                    end else begin
                        ehp_reg  <= ehp_reg - 3'd1;
                        stun_reg <= STUN_LOAD;
                    end
                end else if (frame_tick && stun_reg != 8'd0) begin
                    stun_reg <= stun_reg - 8'd1;
                end
            end

            assign enemy_alive[gi] = alive_reg;
            assign enemy_stun[gi]  = (stun_reg != 8'd0);
        end
    endgenerate

    assign player_dmg = player_step & (|(col_latch_reg & enemy_alive)) & (invuln_reg == 8'd0);

`ifdef DAMAGE_REGEN_EN
    logic [7:0] regen_reg;

    assign regen_fire = frame_tick & ~game_over_reg & (hp_reg < PLAYER_HP_INIT)
                      & (({1'b0, regen_reg} + 9'd1) == 9'(REGEN_FRAMES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regen_reg <= 8'd0;
        end else if (init) begin
            regen_reg <= 8'd0;
        end else if (player_dmg || hp_reg >= PLAYER_HP_INIT) begin
            regen_reg <= 8'd0;
        end else if (frame_tick && !game_over_reg) begin
            regen_reg <= regen_fire ? 8'd0 : regen_reg + 8'd1;
        end
    end
`else
    assign regen_fire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hp_reg        <= PLAYER_HP_INIT;
            invuln_reg    <= 8'd0;
            game_over_reg <= 1'b0;
        end else if (init) begin
            hp_reg        <= PLAYER_HP_INIT;
            invuln_reg    <= 8'd0;
            game_over_reg <= 1'b0;
        end else if (player_dmg) begin
            // Damage takes precedence over both timer decrement and regeneration.
            invuln_reg <= INVULN_LOAD;
            hp_reg     <= (hp_reg == 3'd0) ? 3'd0 : hp_reg - 3'd1;
            if (hp_reg <= 3'd1) game_over_reg <= 1'b1;
        end else begin
            if (frame_tick && invuln_reg != 8'd0) invuln_reg <= invuln_reg - 8'd1;
            if (regen_fire) hp_reg <= hp_reg + 3'd1;
        end
    end

    assign player_hp     = hp_reg;
    assign player_invuln = (invuln_reg != 8'd0);
    assign game_over     = game_over_reg;
    assign all_cleared   = (enemy_alive == 3'b000);

endmodule

// File: tb/tb_damage_controller.sv
// Self-checking bench for damage_controller: vector table, corner sequences, randomized passes.
module tb_damage_controller;

    localparam int P_HP = 6;
    localparam int E_HP = 3;
    localparam int INV  = 60;
    localparam int STUN = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic       frame_tick = 1'b0;
    logic       collision_done = 1'b0;
    logic [2:0] c_e_collision = 3'b000;
    logic [2:0] e_hit = 3'b000;
    logic [2:0] player_hp;
    logic       player_invuln;
    logic [2:0] enemy_alive;
    logic [2:0] enemy_stun;
    logic       game_over;
    logic       all_cleared;
    logic       update_done;

    int total = 0;
    int bad = 0;

    damage_controller dut (
        .clock(clock), .reset(reset), .init(init), .frame_tick(frame_tick),
        .collision_done(collision_done), .c_e_collision(c_e_collision), .e_hit(e_hit),
        .player_hp(player_hp), .player_invuln(player_invuln), .enemy_alive(enemy_alive),
        .enemy_stun(enemy_stun), .game_over(game_over), .all_cleared(all_cleared),
        .update_done(update_done)
    );

    always #5 clock = ~clock;

    // Reference model: game rules as plain integers, one call per frame or per pass.
    int m_php, m_inv, m_go;
    int m_ehp[3];
    int m_stun[3];

    function automatic void model_reset();
        m_php = P_HP; m_inv = 0; m_go = 0;
        for (int n = 0; n < 3; n++) begin m_ehp[n] = E_HP; m_stun[n] = 0; end
    endfunction

    function automatic void model_tick();
        if (m_inv > 0) m_inv--;
        for (int n = 0; n < 3; n++) if (m_stun[n] > 0) m_stun[n]--;
    endfunction

    function automatic void model_pass(input logic [2:0] col, input logic [2:0] hit);
        bit touched = 0;
        if (m_go != 0) return;
        for (int n = 0; n < 3; n++) begin
            if (hit[n] && m_ehp[n] > 0 && m_stun[n] == 0) begin
                m_ehp[n]--;
                m_stun[n] = (m_ehp[n] == 0) ? 0 : STUN;
            end
        end
        for (int n = 0; n < 3; n++) if (col[n] && m_ehp[n] > 0) touched = 1;
        if (touched && m_inv == 0) begin
            m_php--;
            m_inv = INV;
            if (m_php == 0) m_go = 1;
        end
    endfunction

    task automatic compare(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        logic [11:0] act, exp;
        logic [2:0]  ea, es;
        for (int n = 0; n < 3; n++) begin
            ea[n] = (m_ehp[n] > 0);
            es[n] = (m_stun[n] > 0);
        end
        act = {player_hp, player_invuln, enemy_alive, enemy_stun, game_over, all_cleared};
        exp = {3'(m_php), (m_inv > 0), ea, es, (m_go != 0), (ea == 3'b000)};
        compare({name, ".state"}, int'(act), int'(exp));
    endtask

    task automatic ticks(input int n);
        if (n > 0) begin
            @(posedge clock); #1;
            frame_tick = 1'b1;
            repeat (n) @(posedge clock);
            #1;
            frame_tick = 1'b0;
            for (int i = 0; i < n; i++) model_tick();
        end
    endtask

    // One done pulse; inputs are inverted right after the latch cycle to prove they were captured.
    task automatic run_pass(input string name, input logic [2:0] col, input logic [2:0] hit);
        int cnt = 0;
        int lat = -1;
        bit expect_done = (m_go == 0);
        @(posedge clock); #1;
        c_e_collision = col; e_hit = hit; collision_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (update_done) begin
                cnt++;
                if (lat < 0) lat = i;
            end
            @(posedge clock); #1;
            if (i == 0) collision_done = 1'b0;
            if (i == 1) begin c_e_collision = ~col; e_hit = ~hit; end
        end
        @(negedge clock);
        model_pass(col, hit);
        if (expect_done) begin
            compare({name, ".done_cnt"}, cnt, 1);
            compare({name, ".latency"}, lat, 6);
        end else begin
            compare({name, ".no_done"}, cnt, 0);
        end
        check_state(name);
    endtask

    typedef struct {
        logic [2:0] col;
        logic [2:0] hit;
        int         pre_ticks;
        logic [2:0] exp_hp;
        logic [2:0] exp_alive;
        logic       exp_go;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int cnt;
        int lat;

        vecs[0]  = '{3'b000, 3'b001, 0,  3'd6, 3'b111, 1'b0};
        vecs[1]  = '{3'b000, 3'b001, 20, 3'd6, 3'b111, 1'b0};
        vecs[2]  = '{3'b000, 3'b001, 25, 3'd6, 3'b110, 1'b0};
        vecs[3]  = '{3'b000, 3'b010, 0,  3'd6, 3'b110, 1'b0};
        vecs[4]  = '{3'b000, 3'b010, 5,  3'd6, 3'b110, 1'b0};
        vecs[5]  = '{3'b111, 3'b000, 0,  3'd5, 3'b110, 1'b0};
        vecs[6]  = '{3'b111, 3'b000, 10, 3'd5, 3'b110, 1'b0};
        vecs[7]  = '{3'b001, 3'b000, 60, 3'd5, 3'b110, 1'b0};
        vecs[8]  = '{3'b010, 3'b010, 0,  3'd4, 3'b110, 1'b0};
        vecs[9]  = '{3'b000, 3'b010, 30, 3'd4, 3'b100, 1'b0};
        vecs[10] = '{3'b010, 3'b000, 0,  3'd4, 3'b100, 1'b0};
        vecs[11] = '{3'b110, 3'b100, 60, 3'd3, 3'b100, 1'b0};
        vecs[12] = '{3'b100, 3'b000, 60, 3'd2, 3'b100, 1'b0};
        vecs[13] = '{3'b100, 3'b000, 60, 3'd1, 3'b100, 1'b0};
        vecs[14] = '{3'b100, 3'b000, 60, 3'd0, 3'b100, 1'b1};
        vecs[15] = '{3'b100, 3'b001, 60, 3'd0, 3'b100, 1'b1};

        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check_state("reset");
        compare("reset.update_done", int'(update_done), 0);

        for (int v = 0; v < 16; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            ticks(vecs[v].pre_ticks);
            run_pass(nm, vecs[v].col, vecs[v].hit);
            compare({nm, ".table"}, int'({player_hp, enemy_alive, game_over}),
                    int'({vecs[v].exp_hp, vecs[v].exp_alive, vecs[v].exp_go}));
            $display("vec%0d col=%b hit=%b hp=%0d alive=%b go=%b", v, vecs[v].col, vecs[v].hit,
                     player_hp, enemy_alive, game_over);
        end

        // init restarts everything, including after game over
        @(posedge clock); #1 init = 1'b1;
        @(posedge clock); #1 init = 1'b0;
        model_reset();
        @(negedge clock);
        check_state("init");

        // done held high for 10 cycles starts exactly one pass
        @(posedge clock); #1;
        c_e_collision = 3'b000; e_hit = 3'b000; collision_done = 1'b1;
        cnt = 0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (update_done) begin cnt++; if (lat < 0) lat = i; end
            @(posedge clock); #1;
            if (i == 9) collision_done = 1'b0;
        end
        compare("held.done_cnt", cnt, 1);
        compare("held.latency", lat, 6);
        $display("held-high done: passes=%0d latency=%0d", cnt, lat);

        // init three cycles after the edge aborts the pass
        @(posedge clock); #1;
        e_hit = 3'b111; collision_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (update_done) cnt++;
            @(posedge clock); #1;
            if (i == 0) collision_done = 1'b0;
            if (i == 2) init = 1'b1;
            if (i == 3) init = 1'b0;
        end
        compare("abort.no_done", cnt, 0);
        @(negedge clock);
        check_state("abort");
        $display("init abort: update_done pulses=%0d", cnt);

        // clear all three enemies
        for (int k = 0; k < 3; k++) begin
            ticks(STUN);
            run_pass($sformatf("clear%0d", k), 3'b000, 3'b111);
            $display("clear%0d alive=%b all_cleared=%b", k, enemy_alive, all_cleared);
        end
        compare("clear.all_cleared", int'(all_cleared), 1);

        @(posedge clock); #1 init = 1'b1;
        @(posedge clock); #1 init = 1'b0;
        model_reset();

        for (int r = 0; r < 60; r++) begin
            logic [2:0] rc, rh;
            rc = 3'($urandom_range(0, 7));
            rh = 3'($urandom_range(0, 7));
            ticks($urandom_range(0, 70));
            run_pass($sformatf("rnd%0d", r), rc, rh);
            $display("rnd%0d col=%b hit=%b hp=%0d alive=%b stun=%b go=%b", r, rc, rh,
                     player_hp, enemy_alive, enemy_stun, game_over);
            if (m_go != 0 && $urandom_range(0, 1) == 1) begin
                @(posedge clock); #1 init = 1'b1;
                @(posedge clock); #1 init = 1'b0;
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
